lc3b_fetch: RTL and testbench

Instruction fetch sequencer that feeds the instruction register: holds the PC, issues word reads to instruction memory, and delivers each returned word with a one-cycle load strobe. Sits between the control FSM (fetch requests, PC redirects) and the memory port. Single outstanding read. Redirect-while-busy squashes the in-flight word. A watchdog flags memory that never responds.

---
 rtl/lc3b_fetch.sv | 160 ++++++++++++++++
 tb/tb_lc3b_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_fetch.sv
// lc3b_fetch: instruction fetch sequencer between the control FSM and the
// instruction memory port. It holds the PC and issues one word read at a time.
// It delivers each returned word to the instruction register with a one-cycle
// ir_load strobe.
//
// A redirect (pc_load) that arrives while a read is outstanding squashes that
// read. The memory still completes it, but the returned word is dropped. A
// fresh request then goes out at the new target.
//
// A watchdog sets a sticky error when the memory keeps a request waiting too
// long.
//
// Parameters:
//   RESET_PC    PC after reset (bit 0 is cleared)
//   TIMEOUT     cycles REQ may wait for mem_resp before err_timeout; 0 = off
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   fetch_req           next-instruction request (honoured in IDLE only)
//   pc_load, pc_in      redirect strobe and target (bit 0 forced to 0)
//   mem_address         read address to instruction memory
//   mem_read            read request, held until mem_resp
//   mem_resp, mem_rdata completion pulse and read data
//   ir_load, ir_data    instruction register strobe and captured word
//   pc_out              current PC
//   busy                high while in REQ or DELIVER
//   err_timeout         sticky watchdog error
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for fetch_req; redirects update pc directly
// REQ     | read outstanding (mem_read=1), or one-cycle gap after a squash
// DELIVER | ir_load asserted for this single cycle, then back to IDLE
module lc3b_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic        pc_load,
   input  logic [15:0] pc_in,
   output logic [15:0] mem_address,
   output logic        mem_read,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata,
   output logic        ir_load,
   output logic [15:0] ir_data,
   output logic [15:0] pc_out,
   output logic        busy,
   output logic        err_timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DELIVER = 2'd2
   } state_t;

   localparam logic [15:0] TO = 16'(TIMEOUT);

   state_t      state;
   logic [15:0] pc;
   logic [15:0] req_addr;
   logic        squash;
   logic [15:0] wait_cnt;
   logic [15:0] wait_cnt_inc;
   logic [15:0] target;

   assign target       = pc_in & 16'hFFFE;
   assign wait_cnt_inc = wait_cnt + 16'd1;

   // While a squashed read is still outstanding, the memory must keep seeing
   // the address it was given. pc already points at the redirect target.
   assign mem_address = squash ? req_addr : {pc[15:1], 1'b0};
   assign pc_out      = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC & 16'hFFFE;
         req_addr    <= 16'h0000;
         ir_data     <= 16'h0000;
         ir_load     <= 1'b0;
         mem_read    <= 1'b0;
         squash      <= 1'b0;
         wait_cnt    <= 16'h0000;
         err_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ir_load <= 1'b0;
         case (state)
            IDLE: begin
               if (pc_load)
                  pc <= target;
               if (fetch_req) begin
                  state    <= REQ;
                  mem_read <= 1'b1;
                  busy     <= 1'b1;
                  wait_cnt <= 16'h0000;
               end
            end

            REQ: begin
               if (!mem_read) begin
                  // Gap cycle after a squashed read. The memory sees mem_read
                  // fall, then a fresh request at the current pc.
                  mem_read <= 1'b1;
                  wait_cnt <= 16'h0000;
                  if (pc_load)
                     pc <= target;
               end else if (mem_resp) begin
                  mem_read <= 1'b0;
                  if (squash || pc_load) begin
                     if (pc_load)
                        pc <= target;
                     squash   <= 1'b0;
                     wait_cnt <= 16'h0000;
                  end else begin
                     ir_data <= mem_rdata;
                     pc      <= pc + 16'd2;
                     ir_load <= 1'b1;
                     state   <= DELIVER;
                  end
               end else begin
                  if (pc_load) begin
                     pc     <= target;
                     squash <= 1'b1;
                     // Capture the in-flight address only on the first
                     // redirect. Later redirects just move pc again.
                     if (!squash)
                        req_addr <= pc;
                  end
                  if (wait_cnt != TO)
                     wait_cnt <= wait_cnt_inc;
                  if ((TO != 16'h0000) && (wait_cnt_inc == TO))
                     err_timeout <= 1'b1;
               end
            end

            DELIVER: begin
               // The word is already in ir_data, so a redirect here only
               // moves pc.
               state <= IDLE;
               busy  <= 1'b0;
               if (pc_load)
                  pc <= target;
            end

            default: begin
               state    <= IDLE;
               mem_read <= 1'b0;
               busy     <= 1'b0;
               squash   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_fetch.sv
module tb_lc3b_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic        pc_load;
   logic [15:0] pc_in;
   logic        mem_resp;
   logic [15:0] mem_rdata;

   logic [15:0] mem_address, mem_address_t4, mem_address_t0;
   logic        mem_read, mem_read_t4, mem_read_t0;
   logic        ir_load, ir_load_t4, ir_load_t0;
   logic [15:0] ir_data, ir_data_t4, ir_data_t0;
   logic [15:0] pc_out, pc_out_t4, pc_out_t0;
   logic        busy, busy_t4, busy_t0;
   logic        err_timeout, err_t4, err_t0;

   int n_checks = 0;
   int n_errors = 0;
   int n_loads  = 0;

   always #5 clk = ~clk;

   lc3b_fetch #(.RESET_PC(16'h3001), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_in(pc_in), .mem_address(mem_address), .mem_read(mem_read),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata), .ir_load(ir_load),
      .ir_data(ir_data), .pc_out(pc_out), .busy(busy),
      .err_timeout(err_timeout));

   lc3b_fetch #(.RESET_PC(16'h3001), .TIMEOUT(4)) dut_t4 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_in(pc_in), .mem_address(mem_address_t4), .mem_read(mem_read_t4),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata), .ir_load(ir_load_t4),
      .ir_data(ir_data_t4), .pc_out(pc_out_t4), .busy(busy_t4),
      .err_timeout(err_t4));

   lc3b_fetch #(.RESET_PC(16'h3001), .TIMEOUT(0)) dut_t0 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
      .pc_in(pc_in), .mem_address(mem_address_t0), .mem_read(mem_read_t0),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata), .ir_load(ir_load_t0),
      .ir_data(ir_data_t0), .pc_out(pc_out_t0), .busy(busy_t0),
      .err_timeout(err_t0));

   always @(negedge clk)
      if (ir_load) n_loads++;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complete fetch at pc=addr with `waits` idle REQ cycles before the response.
   task automatic do_fetch(input string tag, input logic [15:0] addr, input int waits,
                           input logic [15:0] word, input logic [15:0] pc_next);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk({tag, " mem_read"}, 16'(mem_read), 16'h1);
      chk({tag, " addr"}, mem_address, addr);
      chk({tag, " busy"}, 16'(busy), 16'h1);
      for (int i = 0; i < waits; i++) begin
         tick();
         chk({tag, " wait addr"}, mem_address, addr);
      end
      mem_resp  = 1'b1;
      mem_rdata = word;
      tick();
      mem_resp  = 1'b0;
      chk({tag, " ir_load"}, 16'(ir_load), 16'h1);
      chk({tag, " ir_data"}, ir_data, word);
      chk({tag, " pc"}, pc_out, pc_next);
      chk({tag, " rd drop"}, 16'(mem_read), 16'h0);
      tick();
      chk({tag, " ir_load off"}, 16'(ir_load), 16'h0);
      chk({tag, " idle"}, 16'(busy), 16'h0);
   endtask

   initial begin
      reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = 16'h0;
      mem_resp = 1'b0; mem_rdata = 16'h0;
      tick(); tick();
      chk("rst pc", pc_out, 16'h3000);
      chk("rst mem_read", 16'(mem_read), 16'h0);
      chk("rst ir_load", 16'(ir_load), 16'h0);
      chk("rst ir_data", ir_data, 16'h0000);
      chk("rst busy", 16'(busy), 16'h0);
      chk("rst err", 16'(err_timeout), 16'h0);
      reset = 1'b0;
      tick();

      // basic fetch with wait states, then zero-wait back-to-back
      do_fetch("f0", 16'h3000, 3, 16'h1234, 16'h3002);
      do_fetch("f1", 16'h3002, 0, 16'hA001, 16'h3004);
      do_fetch("f2", 16'h3004, 0, 16'hA002, 16'h3006);

      // wrap at top of memory
      pc_load = 1'b1; pc_in = 16'hFFFF;
      tick();
      pc_load = 1'b0;
      chk("idle redirect", pc_out, 16'hFFFE);
      do_fetch("wrap", 16'hFFFE, 0, 16'h7777, 16'h0000);

      // redirect during REQ, squashed response two cycles later
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      pc_load = 1'b1; pc_in = 16'h4005;
      tick();
      pc_load = 1'b0;
      chk("sq pc", pc_out, 16'h4004);
      chk("sq addr held", mem_address, 16'h0000);
      chk("sq mem_read", 16'(mem_read), 16'h1);
      tick();
      mem_resp = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_resp = 1'b0;
      chk("sq gap rd", 16'(mem_read), 16'h0);
      chk("sq no load", 16'(ir_load), 16'h0);
      chk("sq busy", 16'(busy), 16'h1);
      chk("sq gap addr", mem_address, 16'h4004);
      tick();
      chk("sq rereq rd", 16'(mem_read), 16'h1);
      chk("sq rereq addr", mem_address, 16'h4004);
      mem_resp = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      mem_resp = 1'b0;
      chk("sq ir_load", 16'(ir_load), 16'h1);
      chk("sq ir_data", ir_data, 16'hBEEF);
      chk("sq pc next", pc_out, 16'h4006);
      tick();

      // redirect coincident with response
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      mem_resp = 1'b1; mem_rdata = 16'h5555; pc_load = 1'b1; pc_in = 16'h5000;
      tick();
      mem_resp = 1'b0; pc_load = 1'b0;
      chk("co no load", 16'(ir_load), 16'h0);
      chk("co ir_data kept", ir_data, 16'hBEEF);
      chk("co pc", pc_out, 16'h5000);
      chk("co gap rd", 16'(mem_read), 16'h0);
      tick();
      chk("co rereq addr", mem_address, 16'h5000);
      chk("co rereq rd", 16'(mem_read), 16'h1);
      mem_resp = 1'b1; mem_rdata = 16'h6666;
      tick();
      mem_resp = 1'b0;
      chk("co ir_load", 16'(ir_load), 16'h1);
      chk("co ir_data", ir_data, 16'h6666);
      // redirect while delivering
      pc_load = 1'b1; pc_in = 16'h7001;
      tick();
      pc_load = 1'b0;
      chk("dl pc", pc_out, 16'h7000);
      chk("dl ir_data", ir_data, 16'h6666);
      chk("dl idle", 16'(busy), 16'h0);

      // watchdog
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick(); tick(); tick();
      chk("wd t4 early", 16'(err_t4), 16'h0);
      tick();
      chk("wd t4 rise", 16'(err_t4), 16'h1);
      chk("wd t4 still req", 16'(mem_read_t4), 16'h1);
      repeat (6) tick();
      chk("wd t0 off", 16'(err_t0), 16'h0);
      chk("wd main off", 16'(err_timeout), 16'h0);
      mem_resp = 1'b1; mem_rdata = 16'h1111;
      tick();
      mem_resp = 1'b0;
      chk("wd t4 ir_data", ir_data_t4, 16'h1111);
      tick();
      chk("wd t4 sticky", 16'(err_t4), 16'h1);

      // reset mid-REQ
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("mr req", 16'(mem_read), 16'h1);
      reset = 1'b1;
      #1;
      chk("mr rd", 16'(mem_read), 16'h0);
      chk("mr pc", pc_out, 16'h3000);
      chk("mr busy", 16'(busy), 16'h0);
      chk("mr err", 16'(err_t4), 16'h0);
      tick();
      reset = 1'b0;
      mem_resp = 1'b1; mem_rdata = 16'h9999;
      tick();
      mem_resp = 1'b0;
      chk("late resp load", 16'(ir_load), 16'h0);
      chk("late resp busy", 16'(busy), 16'h0);
      chk("late resp pc", pc_out, 16'h3000);
      chk("late resp data", ir_data, 16'h0000);
      tick();

      chk("load count", 16'(n_loads), 16'd7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
